imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Fills the single-cycle core's instruction memory from a byte stream, then releases the core to run.
- Owns the memory write side (W_EN, ADDRESS, W_INSTRUCTION), the read/fetch enable (R_EN) and the core's reset.
- Sits between a host byte source (UART/SPI front end) and the core top; instantiated beside the core in the system top.

Parameters:
- ADDRESS_BITS, 4, instruction memory address port is [ADDRESS_BITS:0]; DEPTH = 2^(ADDRESS_BITS+1) words (32 at default).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-low reset.
- START  input  1  level-sampled request to begin a load; acted on only in IDLE or RUN.
- RX_DATA  input  8  incoming byte.
- RX_VALID  input  1  RX_DATA valid.
- RX_READY  output  1  loader accepts the byte this cycle.
- W_EN  output  1  instruction memory write strobe, one cycle per word.
- ADDRESS  output  ADDRESS_BITS+1  word address for the write.
- W_INSTRUCTION  output  32  word to write.
- R_EN  output  1  fetch enable to core and memory.
- CORE_RST  output  1  active-low core reset; low whenever not in RUN.
- BUSY  output  1  high in HDR, DATA and WRITE.
- DONE  output  1  high in RUN.
- ERR  output  1  sticky: header count exceeded DEPTH.

Behaviour:
- Reset (RST=0 at a CLK edge):
  - State goes to IDLE.
  - All outputs 0: RX_READY, W_EN, ADDRESS, W_INSTRUCTION, R_EN, CORE_RST, BUSY, DONE and ERR. Byte counter, word index and count register are also 0.
  - Memory contents are not touched.
  - Reset mid-load abandons the load; words already written remain.
- States:
  - IDLE: RX_READY=0. START=1 -> HDR.
  - HDR: RX_READY=1. On handshake (RX_VALID & RX_READY), latch COUNT = RX_DATA, then -> DATA.
    - COUNT=0 is interpreted as DEPTH.
    - COUNT>DEPTH is saturated to DEPTH and sets ERR.
  - DATA: RX_READY=1. Bytes are packed little-endian: the first byte goes to [7:0] and the fourth to [31:24]. The 4th handshake -> WRITE next cycle.
  - WRITE: exactly one cycle.
    - Outputs: RX_READY=0, W_EN=1, ADDRESS=word index, W_INSTRUCTION=assembled word.
    - If index == COUNT-1 -> RUN; otherwise index+1 and -> DATA.
  - RUN: R_EN=1, CORE_RST=1, DONE=1, RX_READY=0. START=1 -> HDR.
    - On leaving RUN for HDR, the next cycle has R_EN=0, CORE_RST=0, DONE=0. ERR is cleared and the index is zeroed.
- Throughput: at most 1 byte/cycle. The mandatory WRITE bubble gives 5 cycles minimum per word.
- RX_VALID low stalls in place; partial words are held indefinitely.
- START is ignored in HDR, DATA and WRITE. An RX_VALID byte in IDLE or RUN is not accepted (RX_READY=0).
- ADDRESS and W_INSTRUCTION hold their last values outside WRITE. W_EN is never high outside WRITE.
- The address never wraps: the index stops at COUNT-1 ≤ DEPTH-1.
- Widths: the count register is ADDRESS_BITS+2 bits, enough to hold DEPTH. Compare COUNT > DEPTH at 9-bit width.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - Adds input port STEP (1 bit).
  - In RUN, R_EN is high for exactly one cycle per rising edge of STEP, detected by a registered previous value that resets to 0.
  - CORE_RST and DONE behave as without the macro.
  - STEP held high yields a single pulse.
  - STEP and START both high in RUN: START wins, and R_EN=0 that cycle.
- Undefined: no STEP port; R_EN is held high throughout RUN.

Decomposition:
- Shared package imem_boot_pkg:
  - state encoding localparams IDLE, HDR, DATA, WRITE, RUN;
  - BYTES_PER_WORD=4;
  - byte-counter width 2.
- Sub-module word_packer:
  - 2-bit byte counter plus a 32-bit shift/placement register;
  - outputs word_ready on the 4th byte;
  - cleared by the controller on entering HDR.
- The FSM stays in the loader.

Test Plan:
1. Load COUNT=2, bytes 13 00 00 00, 93 00 10 00. Required: W_EN pulses, ADDRESS=0 with W_INSTRUCTION=32'h00000013, then ADDRESS=1 with 32'h00100093. Next cycle R_EN=1, CORE_RST=1, DONE=1, ERR=0.
2. RX_VALID toggled 1/0 every cycle during DATA. Required: words identical to scenario 1; RX_READY=0 only in WRITE cycles.
3. Header byte 8'h00 with DEPTH=32. Required: exactly 32 writes at ADDRESS 0..31, then RUN. Header 8'h40: 32 writes and ERR=1 stays high in RUN.
4. RST=0 after the 2nd byte of word 1. Required: next cycle all outputs 0 and state IDLE. A new START and a full reload behave as in scenario 1.
5. In RUN, assert START. Required: next cycle R_EN=0, CORE_RST=0, DONE=0, ERR cleared, RX_READY=1. START asserted during DATA has no effect.
6. With SINGLE_STEP_EN, in RUN, STEP held high for 5 cycles. Required: R_EN high for exactly 1 cycle. A second rising edge gives one more pulse.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// controller state encoding and byte-packing constants.
package imem_boot_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        RUN   = 3'd4
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = 2;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// The loader uses the master modport because it masters the memory write
// side; the host/memory environment uses the slave modport.
interface imem_boot_loader_if #(parameter int ADDRESS_BITS = 4);

    logic [7:0]              RX_DATA;
    logic                    RX_VALID;
    logic                    RX_READY;
    logic                    W_EN;
    logic [ADDRESS_BITS:0]   ADDRESS;
    logic [31:0]             W_INSTRUCTION;

    modport master (
        input  RX_DATA, RX_VALID,
        output RX_READY, W_EN, ADDRESS, W_INSTRUCTION
    );

    modport slave (
        output RX_DATA, RX_VALID,
        input  RX_READY, W_EN, ADDRESS, W_INSTRUCTION
    );

endinterface

// File: rtl/imem_boot_loader_word_packer.sv
// Assembles four accepted bytes into a little-endian 32-bit word.
// The first byte ends up in [7:0], the fourth in [31:24].
module word_packer
    import imem_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_ready,
    output logic [31:0] word
);

    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [31:0]           shift_q;

    // Byte counter and shift register; new bytes enter at the top so the
    // oldest byte drifts down to the least significant position.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            shift_q  <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            shift_q  <= '0;
        end else if (byte_valid) begin
            byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
            shift_q  <= {byte_in, shift_q[31:8]};
        end
    end

    assign word_ready = byte_valid && (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
    assign word       = {byte_in, shift_q[31:8]};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: reads a count header and little-endian instruction words
// from a byte stream, writes them into instruction memory, then releases
// the core. Optional macro SINGLE_STEP_EN adds a STEP input that gates
// R_EN to one cycle per STEP rising edge while running.
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int ADDRESS_BITS = 4
)
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
`ifdef SINGLE_STEP_EN
    input  logic                STEP,
`endif
    imem_boot_loader_if.master  bus,
    output logic                R_EN,
    output logic                CORE_RST,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR
);

    localparam int DEPTH = 2 ** (ADDRESS_BITS + 1);
    localparam int CNT_W = ADDRESS_BITS + 2;
    localparam int IDX_W = ADDRESS_BITS + 1;

    state_t             state_q;
    state_t             state_next;
    logic               hs;
    logic               last_word;
    logic               over_depth;
    logic [CNT_W-1:0]   count_q;
    logic [IDX_W-1:0]   index_q;
    logic [IDX_W-1:0]   addr_q;
    logic [31:0]        winstr_q;
    logic               err_q;
    logic               word_ready;
    logic [31:0]        word;

    assign hs         = bus.RX_VALID & bus.RX_READY;
    assign last_word  = ({1'b0, index_q} == (count_q - CNT_W'(1)));
    assign over_depth = ({1'b0, bus.RX_DATA} > 9'(DEPTH));

    word_packer u_packer (
        .clk        (CLK),
        .rst_n      (RST),
        .clear      (state_q == HDR),
        .byte_valid (state_q == DATA && hs),
        .byte_in    (bus.RX_DATA),
        .word_ready (word_ready),
        .word       (word)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_next;
    end

    // Next-state selection.
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:    if (START) state_next = HDR;
            HDR:     if (hs) state_next = DATA;
            DATA:    if (word_ready) state_next = WRITE;
            WRITE:   state_next = last_word ? RUN : DATA;
            RUN:     if (START) state_next = HDR;
            default: state_next = IDLE;
        endcase
    end

    // Count, word index, write address/data and sticky error bookkeeping.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            count_q  <= '0;
            index_q  <= '0;
            addr_q   <= '0;
            winstr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_q != HDR && state_next == HDR) begin
                index_q <= '0;
                err_q   <= 1'b0;
            end
            if (state_q == HDR && hs) begin
                if (bus.RX_DATA == 8'd0 || over_depth) count_q <= CNT_W'(DEPTH);
                else                                   count_q <= CNT_W'(bus.RX_DATA);
                if (over_depth) err_q <= 1'b1;
            end
            if (state_q == DATA && word_ready) begin
                addr_q   <= index_q;
                winstr_q <= word;
            end
            if (state_q == WRITE && !last_word) index_q <= index_q + IDX_W'(1);
        end
    end

`ifdef SINGLE_STEP_EN
    logic step_q;

    // Previous STEP value for rising-edge detection.
    always_ff @(posedge CLK) begin
        if (!RST) step_q <= 1'b0;
        else      step_q <= STEP;
    end
`endif

    // Outputs decoded from the current state.
    always_comb begin
        bus.RX_READY = 1'b0;
        bus.W_EN     = 1'b0;
        R_EN         = 1'b0;
        CORE_RST     = 1'b0;
        BUSY         = 1'b0;
        DONE         = 1'b0;
        case (state_q)
            HDR, DATA: begin
                bus.RX_READY = 1'b1;
                BUSY         = 1'b1;
            end
            WRITE: begin
                bus.W_EN = 1'b1;
                BUSY     = 1'b1;
            end
            RUN: begin
                CORE_RST = 1'b1;
                DONE     = 1'b1;
`ifdef SINGLE_STEP_EN
                R_EN     = STEP & ~step_q & ~START;
`else
                R_EN     = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign bus.ADDRESS       = addr_q;
    assign bus.W_INSTRUCTION = winstr_q;
    assign ERR               = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed testbench for imem_boot_loader (default build or SINGLE_STEP_EN).
module tb_imem_boot_loader;
    import imem_boot_pkg::*;

    logic CLK;
    logic RST;
    logic START;
    logic R_EN, CORE_RST, BUSY, DONE, ERR;
`ifdef SINGLE_STEP_EN
    logic STEP;
    localparam bit STEP_BUILD = 1'b1;
`else
    localparam bit STEP_BUILD = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] words [64];
    logic [4:0]  wr_addr [$];
    logic [31:0] wr_data [$];

    imem_boot_loader_if #(.ADDRESS_BITS(4)) bus ();

    imem_boot_loader #(.ADDRESS_BITS(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
`ifdef SINGLE_STEP_EN
        .STEP     (STEP),
`endif
        .bus      (bus),
        .R_EN     (R_EN),
        .CORE_RST (CORE_RST),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Record every memory write seen during a WRITE cycle.
    always @(negedge CLK) begin
        if (bus.W_EN === 1'b1) begin
            wr_addr.push_back(bus.ADDRESS);
            wr_data.push_back(bus.W_INSTRUCTION);
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Offer one byte (called at a negedge) and return at the negedge after it is taken.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        t = 0;
        bus.RX_DATA  = b;
        bus.RX_VALID = 1'b1;
        while (bus.RX_READY !== 1'b1 && t < 20) begin
            if (gap) check_output("ready_low_only_in_write", {31'd0, bus.W_EN}, 32'd1);
            @(negedge CLK);
            t++;
        end
        if (t >= 20) check_output("handshake_timeout", t, 32'd0);
        @(negedge CLK);
        bus.RX_VALID = 1'b0;
        if (gap) begin
            check_output("ready_xor_wen", {31'd0, bus.RX_READY ^ bus.W_EN}, 32'd1);
            @(negedge CLK);
        end
    endtask

    task automatic load_words(input logic [7:0] hdr, input int n, input bit gap, input bit start_mid);
        send_byte(hdr, 1'b0);
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < 4; b++) begin
                if (start_mid && w == 0 && b == 2) START = 1'b1;
                send_byte(words[w][8*b +: 8], gap);
                if (start_mid && w == 0 && b == 2) begin
                    check_output("start_ignored_busy", {31'd0, BUSY}, 32'd1);
                    START = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_run();
        int t;
        t = 0;
        while (DONE !== 1'b1 && t < 40) begin
            @(negedge CLK);
            t++;
        end
        check_output("reach_run", {31'd0, DONE}, 32'd1);
    endtask

    task automatic start_pulse();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic check_two_words(input string tag);
        check_output({tag, "_wcount"}, wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            check_output({tag, "_addr0"}, {27'd0, wr_addr[0]}, 32'd0);
            check_output({tag, "_data0"}, wr_data[0], 32'h00000013);
            check_output({tag, "_addr1"}, {27'd0, wr_addr[1]}, 32'd1);
            check_output({tag, "_data1"}, wr_data[1], 32'h00100093);
        end
        check_output({tag, "_run_ren"}, {31'd0, R_EN}, {31'd0, !STEP_BUILD});
        check_output({tag, "_run_corerst"}, {31'd0, CORE_RST}, 32'd1);
        check_output({tag, "_run_err"}, {31'd0, ERR}, 32'd0);
        check_output({tag, "_run_busy"}, {31'd0, BUSY}, 32'd0);
    endtask

    task automatic two_word_setup();
        words[0] = 32'h00000013;
        words[1] = 32'h00100093;
        wr_addr.delete();
        wr_data.delete();
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int pulses;
        RST          = 1'b0;
        START        = 1'b0;
        bus.RX_DATA  = 8'h00;
        bus.RX_VALID = 1'b0;
`ifdef SINGLE_STEP_EN
        STEP         = 1'b0;
`endif
        repeat (3) @(negedge CLK);

        // Reset state
        check_output("reset_flags", {25'd0, bus.RX_READY, bus.W_EN, R_EN, CORE_RST, BUSY, DONE, ERR}, 32'd0);
        check_output("reset_addr", {27'd0, bus.ADDRESS}, 32'd0);
        check_output("reset_winstr", bus.W_INSTRUCTION, 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        check_output("idle_ready", {31'd0, bus.RX_READY}, 32'd0);

        // Scenario 1: two-word load
        $display("[TB] two-word load");
        two_word_setup();
        start_pulse();
        check_output("hdr_ready", {31'd0, bus.RX_READY}, 32'd1);
        check_output("hdr_busy", {31'd0, BUSY}, 32'd1);
        load_words(8'd2, 2, 1'b0, 1'b0);
        wait_run();
        check_two_words("s1");
        check_output("s1_hold_addr", {27'd0, bus.ADDRESS}, 32'd1);
        check_output("s1_hold_data", bus.W_INSTRUCTION, 32'h00100093);

        // Scenario 2: RX_VALID toggling during DATA
        $display("[TB] toggled valid load");
        two_word_setup();
        start_pulse();
        load_words(8'd2, 2, 1'b1, 1'b0);
        wait_run();
        check_two_words("s2");

        // Scenario 3a: header 0 means a full-depth load
        $display("[TB] full depth header 0");
        for (int i = 0; i < 32; i++) words[i] = 32'hC0DE_0000 + i;
        wr_addr.delete();
        wr_data.delete();
        start_pulse();
        load_words(8'h00, 32, 1'b0, 1'b0);
        wait_run();
        check_output("s3a_wcount", wr_addr.size(), 32'd32);
        if (wr_addr.size() == 32) begin
            for (int i = 0; i < 32; i++) begin
                check_output("s3a_addr", {27'd0, wr_addr[i]}, i);
                check_output("s3a_data", wr_data[i], 32'hC0DE_0000 + i);
            end
        end
        check_output("s3a_err", {31'd0, ERR}, 32'd0);

        // Scenario 3b: oversize header saturates and flags an error
        $display("[TB] oversize header 0x40");
        for (int i = 0; i < 32; i++) words[i] = 32'h5A00_0000 + (i << 8);
        wr_addr.delete();
        wr_data.delete();
        start_pulse();
        load_words(8'h40, 32, 1'b0, 1'b0);
        check_output("s3b_err_in_load", {31'd0, ERR}, 32'd1);
        wait_run();
        check_output("s3b_wcount", wr_addr.size(), 32'd32);
        if (wr_addr.size() == 32) begin
            check_output("s3b_last_addr", {27'd0, wr_addr[31]}, 32'd31);
            check_output("s3b_last_data", wr_data[31], 32'h5A00_1F00);
        end
        check_output("s3b_err_run", {31'd0, ERR}, 32'd1);
        @(negedge CLK);
        check_output("s3b_err_sticky", {31'd0, ERR}, 32'd1);

        // Scenario 5: START in RUN restarts; START during DATA ignored
        $display("[TB] restart from run");
        two_word_setup();
        start_pulse();
        check_output("s5_flags", {27'd0, R_EN, CORE_RST, DONE, ERR, bus.RX_READY}, 32'd1);
        load_words(8'd2, 2, 1'b0, 1'b1);
        wait_run();
        check_two_words("s5");

        // Scenario 4: reset mid-load, then reload
        $display("[TB] reset mid-load");
        two_word_setup();
        start_pulse();
        send_byte(8'd2, 1'b0);
        for (int b = 0; b < 4; b++) send_byte(words[0][8*b +: 8], 1'b0);
        send_byte(8'h93, 1'b0);
        send_byte(8'h00, 1'b0);
        RST = 1'b0;
        @(negedge CLK);
        check_output("s4_flags", {25'd0, bus.RX_READY, bus.W_EN, R_EN, CORE_RST, BUSY, DONE, ERR}, 32'd0);
        check_output("s4_addr", {27'd0, bus.ADDRESS}, 32'd0);
        check_output("s4_winstr", bus.W_INSTRUCTION, 32'd0);
        check_output("s4_partial_wcount", wr_addr.size(), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        wr_addr.delete();
        wr_data.delete();
        start_pulse();
        load_words(8'd2, 2, 1'b0, 1'b0);
        wait_run();
        check_two_words("s4");

`ifdef SINGLE_STEP_EN
        // Scenario 6: single-step pulses
        $display("[TB] single step");
        pulses = 0;
        STEP = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (R_EN === 1'b1) pulses++;
            @(negedge CLK);
        end
        check_output("s6_first_pulses", pulses, 32'd1);
        STEP = 1'b0;
        repeat (2) @(negedge CLK);
        pulses = 0;
        STEP = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (R_EN === 1'b1) pulses++;
            @(negedge CLK);
        end
        check_output("s6_second_pulses", pulses, 32'd1);
        STEP = 1'b0;
        @(negedge CLK);
        STEP  = 1'b1;
        START = 1'b1;
        #1;
        check_output("s6_start_wins", {31'd0, R_EN}, 32'd0);
        @(negedge CLK);
        START = 1'b0;
        STEP  = 1'b0;
        check_output("s6_restart_hdr", {31'd0, bus.RX_READY}, 32'd1);
`else
        pulses = 0;
        repeat (3) begin
            @(negedge CLK);
            if (R_EN === 1'b1) pulses++;
        end
        check_output("run_ren_held", pulses, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
